// File: rtl/uart_pkg.sv
// Shared UART-side constants, arbiter state encoding and a width helper.
package uart_pkg;

  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // $clog2 that never returns 0, so single-entry indices and counters still get one bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  int unsigned j;

  // Scan from the farthest offset down so the nearest request to ptr_i wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) begin
        idx_o = PW'(j);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin sharing of one byte UART transmitter among N_REQ producers.
// Optional: define UART_TX_ARB_LAST_ON_LF_EN to also end a message on a transmitted LF byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] data_i,
  input  logic [N_REQ-1:0]   last_i,
  output logic [N_REQ-1:0]   done_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic [7:0]         data_o,
  output logic               start_o,
  input  logic               done_i
);

  localparam int unsigned PW = clog2_min1(N_REQ);
  localparam int unsigned WW = clog2_min1(TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] wd_q, wd_d;

  logic [PW-1:0] pick_idx;
  logic          pick_any;
  logic          own_req;
  logic          own_last;
  logic [7:0]    own_data;
  logic [PW-1:0] owner_inc;
  logic          wd_expire;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign own_req   = req_i[owner_q];
  assign own_data  = data_i[{owner_q, 3'b000} +: 8];
  assign owner_inc = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef UART_TX_ARB_LAST_ON_LF_EN
  assign own_last = last_i[owner_q] | (own_data == ASCII_LF);
`else
  assign own_last = last_i[owner_q];
`endif

  // Only idle cycles of the owner count toward revocation.
  assign wd_expire = (TIMEOUT != 0) && !own_req && (wd_q == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          owner_d = pick_idx;
          wd_d    = '0;
        end
      end
      BUSY: begin
        if ((done_i && own_last) || wd_expire) begin
          state_d = IDLE;
          ptr_d   = owner_inc;
          wd_d    = '0;
        end else if (own_req) begin
          wd_d = '0;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_o = '0;
    done_o  = '0;
    start_o = 1'b0;
    data_o  = '0;
    if (state_q == BUSY) begin
      grant_o[owner_q] = 1'b1;
      done_o[owner_q]  = done_i;
      start_o          = own_req;
      data_o           = own_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=2, TIMEOUT=16) with hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]  last = '0;
  logic          done_in = 1'b0;
  logic [N-1:0]  done_o;
  logic [N-1:0]  grant_o;
  logic [7:0]    data_o;
  logic          start_o;

  int n_vec = 0;
  int n_bad = 0;

  uart_tx_arbiter #(
    .N_REQ   (N),
    .TIMEOUT (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req),
    .data_i  (data),
    .last_i  (last),
    .done_o  (done_o),
    .grant_o (grant_o),
    .data_o  (data_o),
    .start_o (start_o),
    .done_i  (done_in)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    done_in = 1'b0;
    last    = '0;
    data    = '0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  // One byte from owner r: check mux and grant, pulse done, check forwarded done.
  task automatic xfer(input int r, input logic [7:0] b, input logic lst, input string tag);
    logic [N-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    data[8*r +: 8] = b;
    last[r] = lst;
    #1;
    check_eq({tag, " data_o"}, 32'(data_o), 32'(b));
    check_eq({tag, " grant"}, 32'(grant_o), 32'(oh));
    check_eq({tag, " start"}, 32'(start_o), 32'(1));
    done_in = 1'b1;
    #1;
    check_eq({tag, " done_o"}, 32'(done_o), 32'(oh));
    tick();
    done_in = 1'b0;
  endtask

  initial begin
    logic [7:0] lf_msg [7];
    lf_msg = '{8'h44, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};

    // Reset state
    do_reset();
    check_eq("rst grant", 32'(grant_o), 32'(0));
    check_eq("rst start", 32'(start_o), 32'(0));
    check_eq("rst done", 32'(done_o), 32'(0));
    check_eq("rst data", 32'(data_o), 32'(0));

    // Single 3-byte message from requester 0
    req = 2'b01;
    data[7:0] = 8'h44;
    #1;
    check_eq("t1 start before grant", 32'(start_o), 32'(0));
    tick();
    xfer(0, 8'h44, 1'b0, "t1 b0");
    xfer(0, 8'h31, 1'b0, "t1 b1");
    xfer(0, 8'h0A, 1'b1, "t1 b2");
    req = '0;
    #1;
    check_eq("t1 release grant", 32'(grant_o), 32'(0));
    check_eq("t1 release start", 32'(start_o), 32'(0));

    // Both requesting: 2-byte messages rotate 0,1,0,1
    do_reset();
    req = 2'b11;
    tick();
    for (int m = 0; m < 4; m++) begin
      int r;
      r = m % 2;
      xfer(r, 8'(8'hA0 + 16 * r + m), 1'b0, $sformatf("t2 m%0d r%0d b0", m, r));
      xfer(r, 8'(8'hC0 + 16 * r + m), 1'b1, $sformatf("t2 m%0d r%0d b1", m, r));
      check_eq($sformatf("t2 m%0d gap grant", m), 32'(grant_o), 32'(0));
      if (m < 3) tick();
    end

    // Watchdog: owner 1 drops req after one byte
    req = 2'b10;
    last = '0;
    tick();
    xfer(1, 8'h55, 1'b0, "t3 b0");
    req = 2'b00;
    #1;
    check_eq("t3 start low", 32'(start_o), 32'(0));
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("t3 held c%0d", i), 32'(grant_o), 32'(2'b10));
      tick();
    end
    check_eq("t3 revoked", 32'(grant_o), 32'(0));
    req = 2'b11;
    tick();
    check_eq("t3 next grant r0", 32'(grant_o), 32'(2'b01));
    xfer(0, 8'h5A, 1'b1, "t3 r0 end");

    // Async reset mid-message with done pending (pointer is 1 beforehand)
    req = 2'b01;
    tick();
    check_eq("t4 grant r0", 32'(grant_o), 32'(2'b01));
    done_in = 1'b1;
    #1;
    check_eq("t4 done before rst", 32'(done_o), 32'(2'b01));
    rst_n = 1'b0;
    #1;
    check_eq("t4 rst start", 32'(start_o), 32'(0));
    check_eq("t4 rst grant", 32'(grant_o), 32'(0));
    check_eq("t4 rst done", 32'(done_o), 32'(0));
    @(posedge clk);
    #3;
    done_in = 1'b0;
    req = 2'b11;
    rst_n = 1'b1;
    #1;
    check_eq("t4 idle after rst", 32'(grant_o), 32'(0));
    tick();
    check_eq("t4 ptr0 grant", 32'(grant_o), 32'(2'b01));
    xfer(0, 8'h66, 1'b1, "t4 end");

    // done_i while idle is ignored (pointer now 1)
    req = 2'b00;
    done_in = 1'b1;
    #1;
    check_eq("t6 idle done_o", 32'(done_o), 32'(0));
    tick();
    done_in = 1'b0;
    check_eq("t6 idle grant", 32'(grant_o), 32'(0));
    req = 2'b11;
    tick();
    check_eq("t6 ptr kept grant r1", 32'(grant_o), 32'(2'b10));
    xfer(1, 8'h77, 1'b1, "t6 end");

    // LF-terminated message with last tied low
    req = 2'b01;
    last = '0;
    tick();
    for (int i = 0; i < 7; i++) begin
      xfer(0, lf_msg[i], 1'b0, $sformatf("t5 b%0d", i));
    end
`ifdef UART_TX_ARB_LAST_ON_LF_EN
    check_eq("t5 lf release", 32'(grant_o), 32'(0));
`else
    check_eq("t5 lf no release", 32'(grant_o), 32'(2'b01));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
